// File: rtl/video_img_pkg.sv
// Shared types and defaults for the video image capture block.
package video_img_pkg;

  // Pixel position counter width (columns and lines).
  localparam int POSW     = 13;

  localparam int DEF_SCRW  = 1920;
  localparam int DEF_SCRH  = 1080;
  localparam int DEF_IMGW  = 320;
  localparam int DEF_IMGH  = 240;
  localparam int DEF_ADDRW = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

endpackage

// File: rtl/video_pos_cnt.sv
// Column/line position tracker for an AXI4-Stream video stream.
// cur_col/cur_row give the position of the beat on the bus this cycle
// (tuser forces 0,0). The flags report tlast arriving early or missing.
module video_pos_cnt import video_img_pkg::*; #(
  parameter int SCRW = DEF_SCRW,
  parameter int SCRH = DEF_SCRH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            beat,
  input  logic            sof,
  input  logic            eol,
  output logic [POSW-1:0] cur_col,
  output logic [POSW-1:0] cur_row,
  output logic            early_eol,
  output logic            late_eol
);

  logic [POSW-1:0] col, row;
  logic            last_col;

  assign cur_col   = sof ? '0 : col;
  assign cur_row   = sof ? '0 : row;
  assign last_col  = (cur_col == POSW'(SCRW - 1));
  assign early_eol = beat & eol & ~last_col;
  assign late_eol  = beat & ~eol & last_col;

  // Advance on every beat; a line ends on tlast or on reaching the last column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (beat) begin
      if (eol || last_col) begin
        col <= '0;
        row <= (cur_row == POSW'(SCRH - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

endmodule

// File: rtl/video_img_capture.sv
// AXI4-Stream video sink: grabs an IMGW x IMGH window of one SCRW x SCRH frame
// into a write-only BRAM port, one pixel per beat, registered write (latency 1).
// Build option: CAPTURE_CONTINUOUS_EN -> re-arm automatically after each frame.
module video_img_capture import video_img_pkg::*; #(
  parameter int DATAW = 24,
  parameter int SCRW  = DEF_SCRW,
  parameter int SCRH  = DEF_SCRH,
  parameter int IMGW  = DEF_IMGW,
  parameter int IMGH  = DEF_IMGH,
  parameter int ADDRW = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             arm,
  input  logic [POSW-1:0]  offw,
  input  logic [POSW-1:0]  offh,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             bram_en_o,
  output logic             bram_we_o,
  output logic [ADDRW-1:0] bram_addr_o,
  output logic [DATAW-1:0] bram_data_o,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW1 = POSW + 1;

  cap_state_e      state, state_nxt;
  logic            run_q;
  logic            beat, sof_beat, arm_ok;
  logic [POSW-1:0] cur_col, cur_row, offw_q, offh_q;
  logic            early_eol, late_eol;
  logic            win_bad, in_win, last_wr, cap_now, wr_now, restart, busy_st;
  logic [ADDRW-1:0] wr_cnt, wr_addr;

  // tready held low until the first clock after reset release.
  assign s_axis_tready = en & run_q;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign sof_beat      = beat & s_axis_tuser;
  assign arm_ok        = en & arm & (state == ST_IDLE);

  video_pos_cnt #(.SCRW(SCRW), .SCRH(SCRH)) u_pos (
    .clk       (clk),
    .rst       (rst),
    .beat      (beat),
    .sof       (s_axis_tuser),
    .eol       (s_axis_tlast),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .early_eol (early_eol),
    .late_eol  (late_eol)
  );

  assign win_bad = ({1'b0, offw} + PW1'(IMGW) > PW1'(SCRW)) ||
                   ({1'b0, offh} + PW1'(IMGH) > PW1'(SCRH));

  assign in_win = (cur_col >= offw_q) && ({1'b0, cur_col} < {1'b0, offw_q} + PW1'(IMGW)) &&
                  (cur_row >= offh_q) && ({1'b0, cur_row} < {1'b0, offh_q} + PW1'(IMGH));

  // Last window pixel is on the BRAM port this cycle; beats now belong to the next frame.
  assign last_wr = bram_we_o && (bram_addr_o == ADDRW'(IMGW * IMGH - 1));
  assign busy_st = (state == ST_WAIT_SOF) || (state == ST_CAPTURE);
  assign cap_now = ((state == ST_CAPTURE) && !last_wr) || ((state == ST_WAIT_SOF) && sof_beat);
  assign restart = (state == ST_CAPTURE) && !last_wr && sof_beat;
  assign wr_now  = cap_now & beat & in_win;
  assign wr_addr = sof_beat ? '0 : wr_cnt;

  // Next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      busy = busy_st;
      unique case (state)
        ST_IDLE:     if (arm && !win_bad) state_nxt = ST_WAIT_SOF;
        ST_WAIT_SOF: if (sof_beat) state_nxt = ST_CAPTURE;
        ST_CAPTURE:  if (last_wr) state_nxt = ST_DONE;
        ST_DONE: begin
          done = 1'b1;
`ifdef CAPTURE_CONTINUOUS_EN
          state_nxt = ST_WAIT_SOF;
`else
          state_nxt = ST_IDLE;
`endif
        end
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, write port, address counter, window offsets and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      run_q       <= 1'b0;
      bram_en_o   <= 1'b0;
      bram_we_o   <= 1'b0;
      bram_addr_o <= '0;
      bram_data_o <= '0;
      wr_cnt      <= '0;
      offw_q      <= '0;
      offh_q      <= '0;
      err         <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_q     <= 1'b1;
      bram_en_o <= wr_now;
      bram_we_o <= wr_now;
      if (wr_now) begin
        bram_addr_o <= wr_addr;
        bram_data_o <= s_axis_tdata;
        wr_cnt      <= wr_addr + 1'b1;
      end else if (cap_now && sof_beat) begin
        wr_cnt <= '0;
      end
      if (arm_ok) begin
        offw_q <= offw;
        offh_q <= offh;
        err    <= win_bad;
      end else if ((busy_st && (early_eol || late_eol)) || restart) begin
        err <= 1'b1;
      end
    end
  end

endmodule
